// File: rtl/tdm_pkg.sv
// tdm_pkg: constants and state encoding shared by both ends of the 8-slot TDM link
package tdm_pkg;
  localparam int TDM_SLOTS = 8;
  localparam int TDM_SEL_W = 3;
  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: wrapping slot counter with clear, load-to-1, increment and terminal count
module tdm_slot_ctr import tdm_pkg::*; #(
  parameter int SLOTS = TDM_SLOTS,
  parameter int SEL_W = TDM_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  output logic [SEL_W-1:0] slot,
  output logic             tc
);
  assign tc = slot == SEL_W'(SLOTS - 1);
  always_ff @(posedge clk)
    if (rst || clr) slot <= '0;
    else if (load) slot <= SEL_W'(1);
    else if (inc) slot <= slot + SEL_W'(1);
endmodule

// File: rtl/tdm_demux8.sv
// tdm_demux8: TDM receiver that reassembles 8 serial slots into a word and flags framing errors
module tdm_demux8 import tdm_pkg::*; #(
  parameter int SLOTS = TDM_SLOTS,
  parameter int SEL_W = TDM_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [SLOTS-1:0] dout,
  output logic             dout_valid,
  output logic [SEL_W-1:0] slot,
  output logic             locked,
  output logic             sync_err
);
  state_t state, state_n;
  logic [SLOTS-1:0] asm_q, asm_set;
  logic start, store, miss, early, tc;
  always_comb begin
    start   = din_valid && frame_sync;
    store   = din_valid && !frame_sync && state == RECV && slot != '0;
    miss    = din_valid && !frame_sync && state == RECV && slot == '0;
    early   = start && state == RECV && slot != '0;
    state_n = miss ? HUNT : start ? RECV : state;
    asm_set = asm_q;
    asm_set[slot] = din;
  end
  tdm_slot_ctr #(.SLOTS(SLOTS), .SEL_W(SEL_W)) u_ctr (
    .clk(clk), .rst(rst), .clr(miss), .load(start), .inc(store), .slot(slot), .tc(tc)
  );
  assign locked = state == RECV;
  always_ff @(posedge clk)
    if (rst) begin
      state      <= HUNT;
      asm_q      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_n;
      dout_valid <= store && tc;
      sync_err   <= miss || early;
      if (start) asm_q <= {{(SLOTS-1){1'b0}}, din};
      else if (store) asm_q <= asm_set;
      if (store && tc) dout <= asm_set;
    end
endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receive end of the 8-slot time-division serial link whose transmitter drives the 8:1 bit multiplexer from a 3-bit slot counter.
- Accepts one bit per valid cycle with a frame marker on slot 0.
- Routes each bit to the channel position given by its slot index.
- Publishes the reassembled 8-bit word with a one-cycle valid pulse, and detects framing errors.

Parameters:
- SLOTS, 8, number of time slots (channels) per frame; must be a power of two.
- SEL_W, 3, slot index width, equal to log2(SLOTS).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit for the current slot.
- din_valid  input  1  din and frame_sync are sampled only when this is high.
- frame_sync  input  1  high with the slot-0 bit of every frame.
- dout  output  SLOTS  last complete frame; dout[k] is the bit received in slot k.
- dout_valid  output  1  one-cycle pulse when dout is updated.
- slot  output  SEL_W  index of the next expected slot.
- locked  output  1  high while in RECV state.
- sync_err  output  1  one-cycle pulse on a framing violation.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (rst), and has priority over every other input.
- Reset values: dout=0, dout_valid=0, sync_err=0, slot=0, locked=0, state=HUNT, internal assembly register=0.
- Sampling: a beat is a cycle with din_valid=1. Cycles with din_valid=0 change no state except clearing the pulses. frame_sync is ignored when din_valid=0.
- Pulses: dout_valid and sync_err are high for exactly one cycle, then return to 0.
- HUNT state (locked=0):
  - Beat with frame_sync=1: store din in assembly bit 0, set slot=1, go to RECV.
  - Beat with frame_sync=0: discard the bit, stay in HUNT, slot stays 0, no sync_err.
- RECV state (locked=1), on each beat:
  - slot!=0 and frame_sync=0: store din in assembly bit [slot], then slot<=slot+1.
  - slot==SLOTS-1 and frame_sync=0: store din in assembly bit SLOTS-1. On the next clock edge, dout <= the full assembled word including this bit, dout_valid=1 for that cycle, and slot wraps to 0. The state stays RECV.
  - slot==0 and frame_sync=1: start a new frame as in HUNT (bit 0 stored, slot=1). No error.
  - slot!=0 and frame_sync=1 (early sync): pulse sync_err, discard the partial frame, treat this beat as slot 0 of a new frame (bit 0 stored, slot=1). State stays RECV and dout is unchanged.
  - slot==0 and frame_sync=0 (missing sync): pulse sync_err, discard the bit, go to HUNT with slot=0.
- Latency: dout and dout_valid update on the clock edge that accepts the slot-(SLOTS-1) beat, so they are visible 1 cycle after that beat is presented.
- Back-to-back: frames with no idle cycles sustain one dout_valid per SLOTS beats.
- Sparse input: gaps in din_valid between beats are allowed anywhere in a frame.
- Hold: dout holds its value between frames. It is never cleared except by reset. A partial frame never reaches dout.
- Mid-operation reset: rst during a frame discards the partial frame and forces all outputs to their reset values on the next edge. A frame_sync in the same cycle as rst is ignored.
- Arithmetic: slot is an unsigned SEL_W-bit counter that wraps naturally from SLOTS-1 to 0.
- Bit mapping: dout[k] equals the bit presented in slot k. This matches the transmitter driving select=k onto data input k.

Decomposition:
- Shared package tdm_pkg:
  - constants TDM_SLOTS=8 and TDM_SEL_W=3;
  - state encoding type with values HUNT=0 and RECV=1;
  - the same constants are used by the transmitter side.
- Submodule tdm_slot_ctr: SEL_W-bit counter with a load-to-1 input, an increment enable, and a terminal-count output (slot==SLOTS-1).
- The top level holds the FSM, the assembly register, and the output registers.

Test Plan:
- Aligned frame: reset, then 8 consecutive beats with frame_sync on the first, bits 1,0,1,1,0,0,1,0 for slots 0..7 → dout=8'b01001101 (0x4D) one cycle after the last beat; dout_valid high for exactly 1 cycle; locked=1.
- Back-to-back with gaps: frames 0xA5 then 0x3C, with din_valid=0 inserted randomly → dout_valid pulses exactly twice; dout reads 0xA5 then 0x3C; slot returns to 0 after each frame.
- Early sync: frame_sync asserted at slot 5 → sync_err pulses once; the partial frame is not published; the next 8 beats produce the correct word; dout keeps its previous value until then.
- Missing sync: after a good frame, the next beat has frame_sync=0 → sync_err pulses once, locked=0, slot=0; beats without sync are ignored until a frame_sync beat relocks.
- Mid-frame reset: rst asserted at slot 4 with frame_sync=1 in the same cycle → next cycle dout=0, dout_valid=0, slot=0, locked=0; no frame is published until a new frame_sync beat.
- Mux loopback: drive the 8:1 multiplexer's select from a free-running 3-bit counter with random 8-bit data, sync at select 0, feed its output to din → every dout equals the transmitted data word over 1000 frames.
